uart_rx_edge_bit_sampler: RTL and testbench

- Upstream timing and sampling stage of the UART receiver.
- Counts oversampling clock edges per bit (edge_cnt) and bits per frame (bit_cnt).
- Majority-votes three oversampled copies of rx_in into sampled_bit.
- Feeds the RX control FSM, which supplies cnt_en and samp_en, and the start/parity/stop checkers and deserializer, which consume sampled_bit when the FSM decides.

---
 rtl/uart_rx_edge_bit_sampler.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_edge_bit_sampler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_edge_bit_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_edge_bit_sampler
//
// Timing and sampling front end of the UART receiver. It counts oversampling
// clock edges inside a bit (edge_cnt, 1..P) and bits inside a frame
// (bit_cnt, start bit = 0). It also takes a 3-sample majority vote of rx_in
// around the middle of each bit.
//
// Optional feature macro: RX_IN_SYNC_EN
//   defined   : rx_in goes through a 2-flop synchronizer (reset to 1) before
//               the sampler. This adds 2 cycles from rx_in to the vote.
//               Counter timing is unchanged.
//   undefined : rx_in feeds the sampler directly and must be synchronous
//               to clk.
//
// Ports:
//   clk          in   oversampling clock
//   rst          in   synchronous, active-high reset
//   rx_in        in   serial line, idle high
//   prescalar    in   oversampling ratio (8/16/32 legal; < 8 treated as 8)
//   cnt_en       in   edge/bit counter enable from the RX FSM
//   samp_en      in   sampler enable from the RX FSM
//   edge_cnt     out  edge position within the current bit, 1..P (0 = idle)
//   bit_cnt      out  bit index within the frame
//   sampled_bit  out  majority-voted value of the most recent bit
//   sample_valid out  one-cycle pulse when sampled_bit is updated
//
// Handshake: there is no valid/ready pair. sample_valid is a pure strobe
// that is high for exactly one cycle, in the same cycle that the new
// sampled_bit first appears. The consumer cannot stall it.
// ---------------------------------------------------------------------------
module uart_rx_edge_bit_sampler #(
  parameter int PRESC_W   = 6,
  parameter int BIT_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic [PRESC_W-1:0]   prescalar,
  input  logic                 cnt_en,
  input  logic                 samp_en,
  output logic [PRESC_W-1:0]   edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 sampled_bit,
  output logic                 sample_valid
);

  localparam logic [PRESC_W-1:0] P_MIN = PRESC_W'(8);
  localparam logic [PRESC_W-1:0] ONE   = PRESC_W'(1);

  // Registered state
  logic [PRESC_W-1:0]   edge_q, edge_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [PRESC_W-1:0]   p_q, p_d;
  logic                 cnt_en_q;
  logic                 s0_q, s0_d;
  logic                 s1_q, s1_d;
  logic                 sampled_q, sampled_d;
  logic                 valid_q, valid_d;

  // Sampler input, optionally synchronized
  logic rx_s;

`ifdef RX_IN_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;
`else
  assign rx_s = rx_in;
`endif

  // A frame starts on the first enabled cycle after a disabled one.
  // Only at that moment is the prescale value taken from the bus.
  logic cnt_start;
  assign cnt_start = cnt_en && !cnt_en_q;

  // Prescale latch
  always_comb begin
    p_d = p_q;
    if (cnt_start) begin
      p_d = (prescalar < P_MIN) ? P_MIN : prescalar;
    end
  end

  // Edge and bit counters.
  // When the counter is enabled again, edge_q is already 0. This is because
  // the previous disabled cycle cleared it. So comparing edge_q against the
  // held p_q is always safe, even on the cycle that latches a new P.
  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (!cnt_en) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (edge_q == p_q) begin
      edge_d = ONE;
      bit_d  = bit_q + BIT_CNT_W'(1);
    end else begin
      edge_d = edge_q + ONE;
    end
  end

  // Sampler. Captures happen at H, H+1 and H+2, where H = P/2.
  // The third sample never needs its own flop: it is voted directly from
  // rx_s on the same edge that would have stored it.
  logic [PRESC_W-1:0] half, half_p1, half_p2;
  logic               vote;

  assign half    = p_q >> 1;
  assign half_p1 = half + ONE;
  assign half_p2 = half + PRESC_W'(2);
  assign vote    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

  always_comb begin
    s0_d      = s0_q;
    s1_d      = s1_q;
    sampled_d = sampled_q;
    valid_d   = 1'b0;
    if (!samp_en || edge_q == ONE) begin
      // Dropping samp_en throws away any partial vote. Each bit also
      // starts from a clean vote at its first edge.
      s0_d = 1'b0;
      s1_d = 1'b0;
    end else begin
      if (edge_q == half)    s0_d = rx_s;
      if (edge_q == half_p1) s1_d = rx_s;
      if (edge_q == half_p2) begin
        sampled_d = vote;
        valid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q    <= '0;
      bit_q     <= '0;
      p_q       <= P_MIN;
      cnt_en_q  <= 1'b0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      sampled_q <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      p_q       <= p_d;
      cnt_en_q  <= cnt_en;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      sampled_q <= sampled_d;
      valid_q   <= valid_d;
    end
  end

  assign edge_cnt     = edge_q;
  assign bit_cnt      = bit_q;
  assign sampled_bit  = sampled_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
module tb_uart_rx_edge_bit_sampler;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescalar;
  logic       cnt_en;
  logic       samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;

  int total;
  int bad;

  logic [5:0] exp_e;
  logic [3:0] exp_b;
  logic       exp_v;
  logic       exp_s;

`ifdef RX_IN_SYNC_EN
  // The synchronizer delays rx_in by 2 cycles. Presenting the stimulus
  // 2 cycles earlier makes it land on the same capture edges.
  localparam int RX_OFF = -2;
`else
  localparam int RX_OFF = 0;
`endif

  uart_rx_edge_bit_sampler #(.PRESC_W(6), .BIT_CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .prescalar    (prescalar),
    .cnt_en       (cnt_en),
    .samp_en      (samp_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({edge_cnt, bit_cnt, sample_valid, sampled_bit} !== {6'd0, 4'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset got e=%0d b=%0d v=%b s=%b want e=0 b=0 v=0 s=1",
               edge_cnt, bit_cnt, sample_valid, sampled_bit);
    end
    rst = 1'b0;
    tick();
  endtask

  // P=8, rx held low
  task automatic test_p8_zero();
    prescalar = 6'd8;
    samp_en   = 1'b1;
    rx_in     = 1'b0;
    cnt_en    = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      exp_e = 6'((n - 1) % 8 + 1);
      exp_b = 4'((n - 1) / 8);
      exp_v = (exp_e == 6'd7);
      exp_s = (n >= 7) ? 1'b0 : 1'b1;
      total++;
      if ({edge_cnt, bit_cnt, sample_valid, sampled_bit} !== {exp_e, exp_b, exp_v, exp_s}) begin
        bad++;
        $display("FAIL p8_zero n=%0d got e=%0d b=%0d v=%b s=%b want e=%0d b=%0d v=%b s=%b",
                 n, edge_cnt, bit_cnt, sample_valid, sampled_bit, exp_e, exp_b, exp_v, exp_s);
      end
    end
    cnt_en  = 1'b0;
    samp_en = 1'b0;
    rx_in   = 1'b1;
    tick();
    total++;
    if ({edge_cnt, bit_cnt, sample_valid, sampled_bit} !== {6'd0, 4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL p8_disable got e=%0d b=%0d v=%b s=%b want e=0 b=0 v=0 s=0",
               edge_cnt, bit_cnt, sample_valid, sampled_bit);
    end
  endtask

  // Prescale latch: a change during a frame is ignored, the next frame
  // uses it. Illegal values fall back to 8. samp_en stays 0 throughout,
  // so sampled_bit must hold 0 and sample_valid must never pulse.
  task automatic test_prescale();
    prescalar = 6'd8;
    cnt_en    = 1'b1;
    for (int n = 1; n <= 48; n++) begin
      if (n == 26) prescalar = 6'd32;
      tick();
      exp_e = 6'((n - 1) % 8 + 1);
      exp_b = 4'((n - 1) / 8);
      total++;
      if ({edge_cnt, bit_cnt, sample_valid, sampled_bit} !== {exp_e, exp_b, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL presc_hold n=%0d got e=%0d b=%0d v=%b s=%b want e=%0d b=%0d v=0 s=0",
                 n, edge_cnt, bit_cnt, sample_valid, sampled_bit, exp_e, exp_b);
      end
    end
    cnt_en = 1'b0;
    tick();
    cnt_en = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      exp_e = 6'((n - 1) % 32 + 1);
      exp_b = 4'((n - 1) / 32);
      total++;
      if ({edge_cnt, bit_cnt, sample_valid, sampled_bit} !== {exp_e, exp_b, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL presc_32 n=%0d got e=%0d b=%0d want e=%0d b=%0d",
                 n, edge_cnt, bit_cnt, exp_e, exp_b);
      end
    end
    cnt_en = 1'b0;
    tick();
    prescalar = 6'd3;
    cnt_en    = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      exp_e = 6'((n - 1) % 8 + 1);
      exp_b = 4'((n - 1) / 8);
      total++;
      if ({edge_cnt, bit_cnt} !== {exp_e, exp_b}) begin
        bad++;
        $display("FAIL presc_illegal n=%0d got e=%0d b=%0d want e=%0d b=%0d",
                 n, edge_cnt, bit_cnt, exp_e, exp_b);
      end
    end
    cnt_en = 1'b0;
    tick();
  endtask

  // P=16, H=8. Bit 0 has a single low sample at edge 8, so the vote is 1.
  // Bit 1 has low samples at edges 8 and 9, so the vote is 0.
  task automatic test_glitch();
    int e_prev;
    int b_prev;
    prescalar = 6'd16;
    samp_en   = 1'b1;
    rx_in     = 1'b1;
    cnt_en    = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      e_prev = (n == 1) ? 0 : (n - 2) % 16 + 1;
      b_prev = (n == 1) ? 0 : (n - 2) / 16;
      if ((b_prev == 0 && e_prev == 8 + RX_OFF) ||
          (b_prev == 1 && (e_prev == 8 + RX_OFF || e_prev == 9 + RX_OFF)))
        rx_in = 1'b0;
      else
        rx_in = 1'b1;
      tick();
      exp_e = 6'((n - 1) % 16 + 1);
      exp_b = 4'((n - 1) / 16);
      exp_v = (exp_e == 6'd11);
      exp_s = (n < 11) ? 1'b0 : ((n < 27) ? 1'b1 : 1'b0);
      total++;
      if ({edge_cnt, bit_cnt, sample_valid, sampled_bit} !== {exp_e, exp_b, exp_v, exp_s}) begin
        bad++;
        $display("FAIL glitch n=%0d got e=%0d b=%0d v=%b s=%b want e=%0d b=%0d v=%b s=%b",
                 n, edge_cnt, bit_cnt, sample_valid, sampled_bit, exp_e, exp_b, exp_v, exp_s);
      end
    end
    cnt_en  = 1'b0;
    samp_en = 1'b0;
    rx_in   = 1'b1;
    tick();
  endtask

  // Full frame 0x55 at P=8: start bit, 8 data bits LSB first, stop bit
  task automatic test_frame_55();
    logic [9:0] frame;
    int         b_prev;
    frame     = {1'b1, 8'h55, 1'b0};
    prescalar = 6'd8;
    samp_en   = 1'b1;
    cnt_en    = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      b_prev = (n == 1) ? 0 : (n - 2) / 8;
      rx_in  = frame[b_prev];
      tick();
      exp_e = 6'((n - 1) % 8 + 1);
      exp_b = 4'((n - 1) / 8);
      exp_v = (exp_e == 6'd7);
      if (exp_v) begin
        exp_s = frame[(n - 1) / 8];
        total++;
        if ({sample_valid, sampled_bit} !== {1'b1, exp_s}) begin
          bad++;
          $display("FAIL frame55 bit=%0d got v=%b s=%b want v=1 s=%b",
                   (n - 1) / 8, sample_valid, sampled_bit, exp_s);
        end
      end
    end
    total++;
    if ({edge_cnt, bit_cnt} !== {6'd8, 4'd9}) begin
      bad++;
      $display("FAIL frame55_end got e=%0d b=%0d want e=8 b=9", edge_cnt, bit_cnt);
    end
    cnt_en  = 1'b0;
    samp_en = 1'b0;
    rx_in   = 1'b1;
    tick();
  endtask

  // Mid-frame abort via cnt_en, then mid-frame reset
  task automatic test_abort_reset();
    prescalar = 6'd8;
    cnt_en    = 1'b1;
    for (int n = 1; n <= 37; n++) tick();
    total++;
    if ({edge_cnt, bit_cnt} !== {6'd5, 4'd4}) begin
      bad++;
      $display("FAIL abort_pre got e=%0d b=%0d want e=5 b=4", edge_cnt, bit_cnt);
    end
    cnt_en = 1'b0;
    tick();
    total++;
    if ({edge_cnt, bit_cnt} !== {6'd0, 4'd0}) begin
      bad++;
      $display("FAIL abort got e=%0d b=%0d want e=0 b=0", edge_cnt, bit_cnt);
    end
    samp_en = 1'b1;
    rx_in   = 1'b0;
    cnt_en  = 1'b1;
    for (int n = 1; n <= 11; n++) tick();
    total++;
    if ({edge_cnt, bit_cnt, sampled_bit} !== {6'd3, 4'd1, 1'b0}) begin
      bad++;
      $display("FAIL rst_pre got e=%0d b=%0d s=%b want e=3 b=1 s=0",
               edge_cnt, bit_cnt, sampled_bit);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({edge_cnt, bit_cnt, sample_valid, sampled_bit} !== {6'd0, 4'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rst_mid got e=%0d b=%0d v=%b s=%b want e=0 b=0 v=0 s=1",
               edge_cnt, bit_cnt, sample_valid, sampled_bit);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({edge_cnt, bit_cnt, sample_valid, sampled_bit} !== {6'd1, 4'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rst_release got e=%0d b=%0d v=%b s=%b want e=1 b=0 v=0 s=1",
               edge_cnt, bit_cnt, sample_valid, sampled_bit);
    end
    cnt_en  = 1'b0;
    samp_en = 1'b0;
    rx_in   = 1'b1;
    tick();
  endtask

  // 17 bits at P=8: bit_cnt wraps 15 -> 0. The counter is then disabled
  // while edge_cnt == P, and the clear must win.
  task automatic test_wrap();
    prescalar = 6'd8;
    cnt_en    = 1'b1;
    for (int n = 1; n <= 136; n++) begin
      tick();
      if (n == 128 || n == 129 || n == 136) begin
        exp_e = 6'((n - 1) % 8 + 1);
        exp_b = 4'(((n - 1) / 8) % 16);
        total++;
        if ({edge_cnt, bit_cnt} !== {exp_e, exp_b}) begin
          bad++;
          $display("FAIL wrap n=%0d got e=%0d b=%0d want e=%0d b=%0d",
                   n, edge_cnt, bit_cnt, exp_e, exp_b);
        end
      end
    end
    cnt_en = 1'b0;
    tick();
    total++;
    if ({edge_cnt, bit_cnt} !== {6'd0, 4'd0}) begin
      bad++;
      $display("FAIL clear_at_p got e=%0d b=%0d want e=0 b=0", edge_cnt, bit_cnt);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    rx_in     = 1'b1;
    prescalar = 6'd8;
    cnt_en    = 1'b0;
    samp_en   = 1'b0;
    test_reset();
    test_p8_zero();
    test_prescale();
    test_glitch();
    test_frame_55();
    test_abort_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
